adder48_seq_arb: RTL

//   Two-requester 48-bit add service built on one shared adder16 slice.

---
 rtl/adder48_seq_arb.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/adder48_seq_arb.sv
// adder48_seq_arb
//   Two-requester 48-bit add service that time-shares one external
//   combinational adder16 slice. A round-robin arbiter accepts one request at
//   a time; the operands are then pushed through the adder16 low slice first,
//   one slice per cycle, with the inter-slice carry held in carry_q. The result
//   is presented on rsp_* and held until rsp_ready.
//
//   Optional feature: define ADDER48_SEQ_OVF_EN to add rsp_ovf, the signed
//   two's-complement overflow flag of the 48-bit add.
//
//   Ports
//     clk, rst              clock, asynchronous active-high reset
//     req_valid/req_ready   per-requester handshake (req_ready one-hot or 0)
//     req_a/req_b           operands, [47:0] requester 0, [95:48] requester 1
//     req_cin               per-requester carry-in
//     rsp_valid/rsp_ready   result handshake
//     rsp_id                requester that owns the result
//     rsp_sum/rsp_cout      A+B+cin modulo 2^48, carry out of bit 47
//     rsp_ovf               signed overflow (only with ADDER48_SEQ_OVF_EN)
//     add_A/add_B/add_c0    drive to the external adder16
//     add_S/add_c16         combinational result of the external adder16
//     busy                  high whenever the FSM is not IDLE
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready offered to the arbitration winner
//   RUN   | one adder16 slice per cycle, counter selects the slice
//   DONE  | result held on rsp_* until rsp_ready
module adder48_seq_arb #(
  parameter int W      = 16,  // fixed by adder16
  parameter int NSLICE = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*W*NSLICE-1:0]   req_a,
  input  logic [2*W*NSLICE-1:0]   req_b,
  input  logic [1:0]              req_cin,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic [W*NSLICE-1:0]     rsp_sum,
  output logic                    rsp_cout,
`ifdef ADDER48_SEQ_OVF_EN
  output logic                    rsp_ovf,
`endif
  output logic [W-1:0]            add_A,
  output logic [W-1:0]            add_B,
  output logic                    add_c0,
  input  logic [W-1:0]            add_S,
  input  logic                    add_c16,
  output logic                    busy
);

  localparam int OW = W * NSLICE;
  localparam int CW = 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   a_q, b_q;
  logic            cin_q;
  logic            id_q;
  logic            carry_q;
  logic [CW-1:0]   cnt_q;
  logic            last_grant_q;

  logic            grant_id;
  logic            grant_any;
  logic            accept;
  logic            last_slice;

  // Arbitration: a lone requester wins; on a tie the requester not granted
  // last time wins. req_ready is gated by rst so nothing is offered while
  // reset is held.
  always_comb begin
    grant_any = |req_valid;
    grant_id  = 1'b0;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant_q;
      default: grant_id = 1'b0;
    endcase
    req_ready = 2'b00;
    if (state_q == IDLE && !rst && grant_any)
      req_ready = grant_id ? 2'b10 : 2'b01;
    accept = |(req_valid & req_ready);
  end

  assign last_slice = (cnt_q == CW'(NSLICE - 1));
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (rsp_valid && rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Adder drive is forced to zero outside RUN so the shared slice sees
  // quiet inputs when this block does not own it.
  always_comb begin
    add_A  = '0;
    add_B  = '0;
    add_c0 = 1'b0;
    if (state_q == RUN) begin
      for (int k = 0; k < NSLICE; k++) begin
        if (cnt_q == CW'(k)) begin
          add_A = a_q[k*W +: W];
          add_B = b_q[k*W +: W];
        end
      end
      add_c0 = (cnt_q == '0) ? cin_q : carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      id_q         <= 1'b0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
`ifdef ADDER48_SEQ_OVF_EN
      rsp_ovf      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;

      if (accept) begin
        a_q          <= grant_id ? req_a[2*OW-1:OW] : req_a[OW-1:0];
        b_q          <= grant_id ? req_b[2*OW-1:OW] : req_b[OW-1:0];
        cin_q        <= grant_id ? req_cin[1] : req_cin[0];
        id_q         <= grant_id;
        last_grant_q <= grant_id;
        cnt_q        <= '0;
        carry_q      <= 1'b0;
      end

      if (state_q == RUN) begin
        for (int k = 0; k < NSLICE; k++) begin
          if (cnt_q == CW'(k))
            rsp_sum[k*W +: W] <= add_S;
        end
        carry_q <= add_c16;
        if (last_slice) begin
          cnt_q     <= '0;
          rsp_valid <= 1'b1;
          rsp_cout  <= add_c16;
          rsp_id    <= id_q;
`ifdef ADDER48_SEQ_OVF_EN
          // Bit 47 of the sum is add_S[W-1] of the top slice, available now.
          rsp_ovf   <= (a_q[OW-1] == b_q[OW-1]) && (add_S[W-1] != a_q[OW-1]);
`endif
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      if (state_q == DONE && rsp_valid && rsp_ready)
        rsp_valid <= 1'b0;
    end
  end

endmodule
